// File: rtl/lcd_frame_sequencer.sv
// lcd_frame_sequencer
//
// Feeds the 4-bit HD44780 nibble driver of a 4x20 character LCD. User logic writes characters
// at random (row, col) positions into an 80-byte frame buffer. After reset the block waits for
// the panel to power up, sends the init command sequence once, then streams whole frames as
// {rs, byte} transfers over a valid/ready handshake. Each line is preceded by its DDRAM
// set-address command, so one frame is 84 transfers (4 commands + 80 characters).
//
// Ports:
//   clk        system clock
//   rst        synchronous active-low reset
//   wr_en      write wr_char into the buffer at (wr_row, wr_col) on this edge
//   wr_row     target row 0..3
//   wr_col     target column 0..19; 20..31 are ignored
//   wr_char    character code
//   refresh    single-cycle request to send the whole frame
//   out_valid  a command/data byte is available to the driver
//   out_ready  driver accepts the byte
//   out_rs     0 = command, 1 = character data
//   out_data   byte to the driver
//   busy       high whenever the sequencer is not idle
//   init_done  high once the init sequence has completed (sticky until reset)

module lcd_frame_sequencer #(
    parameter int unsigned PWR_WAIT = 1000000,  // power-up wait before the first command
    parameter int unsigned CLR_WAIT = 40000     // wait after Clear Display is accepted
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [1:0] wr_row,
    input  logic [4:0] wr_col,
    input  logic [7:0] wr_char,
    input  logic       refresh,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_rs,
    output logic [7:0] out_data,
    output logic       busy,
    output logic       init_done
);

    localparam int unsigned NumCols  = 20;
    localparam int unsigned NumChars = 80;
    localparam int unsigned CntMax   = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
    localparam int unsigned CntW     = $clog2(CntMax + 1);

    // Terminal counts: a wait of N cycles spends exactly N clock edges in its state.
    localparam logic [CntW-1:0] PwrLast = CntW'(PWR_WAIT - 1);
    localparam logic [CntW-1:0] ClrLast = CntW'(CLR_WAIT - 1);

    localparam logic [4:0] LastCol = 5'(NumCols - 1);

    typedef enum logic [2:0] {
        StPwrWait,
        StInit,
        StClrWait,
        StLineCmd,
        StChar,
        StIdle
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [1:0]      init_idx_q;
    logic [1:0]      row_q;
    logic [4:0]      col_q;
    logic            pending_q;

    logic [7:0] frame_mem [NumChars];

    logic       xfer;
    logic [7:0] line_first_char;
    logic [7:0] next_char;
    logic [4:0] next_col;

    // row*20 + col, built from shifts so it stays a small adder.
    function automatic logic [6:0] buf_index(input logic [1:0] row, input logic [4:0] col);
        return 7'({row, 4'b0000}) + 7'({row, 2'b00}) + 7'(col);
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h28;  // function set: 4-bit, 2 lines, 5x8
            2'd1:    return 8'h0C;  // display on, cursor off
            2'd2:    return 8'h06;  // entry mode: increment, no shift
            default: return 8'h01;  // clear display
        endcase
    endfunction

    // DDRAM start address of each line on a 4x20 panel.
    function automatic logic [7:0] line_cmd(input logic [1:0] row);
        case (row)
            2'd0:    return 8'h80;
            2'd1:    return 8'hC0;
            2'd2:    return 8'h94;
            default: return 8'hD4;
        endcase
    endfunction

    //--------------------------------------------------------------------------------------------
    // Frame buffer. Writes land on the next edge in every state; the scan-out reads the old
    // contents on the same edge, so a same-cycle write to the index being loaded shows up only
    // in a later frame.
    //--------------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(NumChars); i++) begin
                frame_mem[i] <= 8'h20;
            end
        end else if (wr_en && (wr_col < 5'(NumCols))) begin
            frame_mem[buf_index(wr_row, wr_col)] <= wr_char;
        end
    end

    //--------------------------------------------------------------------------------------------
    // Buffer read ports for the output register. next_col is clamped at the end of a line so
    // the unused read never leaves the buffer.
    //--------------------------------------------------------------------------------------------
    always_comb begin
        xfer            = out_valid && out_ready;
        next_col        = (col_q == LastCol) ? 5'd0 : col_q + 5'd1;
        line_first_char = frame_mem[buf_index(row_q, 5'd0)];
        next_char       = frame_mem[buf_index(row_q, next_col)];
    end

    //--------------------------------------------------------------------------------------------
    // Sequencer. All outputs are registered; the next byte is loaded on the edge that accepts the
    // current one, so with out_ready held high the stream runs one transfer per cycle. While
    // stalled nothing in the output register changes.
    //--------------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StPwrWait;
            cnt_q      <= '0;
            init_idx_q <= 2'd0;
            row_q      <= 2'd0;
            col_q      <= 5'd0;
            pending_q  <= 1'b0;
            out_valid  <= 1'b0;
            out_rs     <= 1'b0;
            out_data   <= 8'h00;
            busy       <= 1'b1;
            init_done  <= 1'b0;
        end else begin
            // Requests while busy coalesce into a single extra frame.
            if (refresh && (state_q != StIdle)) begin
                pending_q <= 1'b1;
            end

            case (state_q)
                StPwrWait: begin
                    if (cnt_q == PwrLast) begin
                        cnt_q      <= '0;
                        init_idx_q <= 2'd0;
                        state_q    <= StInit;
                        out_valid  <= 1'b1;
                        out_rs     <= 1'b0;
                        out_data   <= init_cmd(2'd0);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StInit: begin
                    if (xfer) begin
                        if (init_idx_q == 2'd3) begin
                            out_valid <= 1'b0;
                            cnt_q     <= '0;
                            state_q   <= StClrWait;
                        end else begin
                            init_idx_q <= init_idx_q + 2'd1;
                            out_data   <= init_cmd(init_idx_q + 2'd1);
                        end
                    end
                end

                StClrWait: begin
                    if (cnt_q == ClrLast) begin
                        cnt_q     <= '0;
                        init_done <= 1'b1;
                        row_q     <= 2'd0;
                        state_q   <= StLineCmd;
                        out_valid <= 1'b1;
                        out_rs    <= 1'b0;
                        out_data  <= line_cmd(2'd0);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StLineCmd: begin
                    if (xfer) begin
                        col_q    <= 5'd0;
                        state_q  <= StChar;
                        out_rs   <= 1'b1;
                        out_data <= line_first_char;
                    end
                end

                StChar: begin
                    if (xfer) begin
                        if (col_q == LastCol) begin
                            col_q <= 5'd0;
                            if (row_q == 2'd3) begin
                                state_q   <= StIdle;
                                out_valid <= 1'b0;
                                out_rs    <= 1'b0;
                                busy      <= 1'b0;
                            end else begin
                                row_q    <= row_q + 2'd1;
                                state_q  <= StLineCmd;
                                out_rs   <= 1'b0;
                                out_data <= line_cmd(row_q + 2'd1);
                            end
                        end else begin
                            col_q    <= next_col;
                            out_data <= next_char;
                        end
                    end
                end

                StIdle: begin
                    // A pending frame starts one cycle after entering idle, so busy dips once.
                    if (refresh || pending_q) begin
                        pending_q <= 1'b0;
                        row_q     <= 2'd0;
                        state_q   <= StLineCmd;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_rs    <= 1'b0;
                        out_data  <= line_cmd(2'd0);
                    end
                end

                default: begin
                    state_q <= StPwrWait;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Scoreboard bench for lcd_frame_sequencer. Stimulus pushes the expected {rs, byte} stream,
// with optional inter-transfer gap and idle-cycle expectations, into a queue; the monitor pops
// and compares on every accepted transfer. Inputs change 2 time units after the rising edge,
// outputs are sampled on the falling edge.

module tb_lcd_frame_sequencer;

    localparam int unsigned PwrWait = 16;
    localparam int unsigned ClrWait = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_row = 2'd0;
    logic [4:0] wr_col = 5'd0;
    logic [7:0] wr_char = 8'h00;
    logic       refresh = 1'b0;
    logic       out_ready = 1'b1;
    logic       out_valid;
    logic       out_rs;
    logic [7:0] out_data;
    logic       busy;
    logic       init_done;

    always #5 clk = ~clk;

    lcd_frame_sequencer #(
        .PWR_WAIT(PwrWait),
        .CLR_WAIT(ClrWait)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_row   (wr_row),
        .wr_col   (wr_col),
        .wr_char  (wr_char),
        .refresh  (refresh),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_rs   (out_rs),
        .out_data (out_data),
        .busy     (busy),
        .init_done(init_done)
    );

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         gap;   // falling edges since previous transfer (or reset), -1 = don't care
        int         idle;  // busy-low cycles just before this transfer, -1 = don't care
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_cyc = 0;
    int idle_cnt = 0;
    int xfer_n = 0;

    logic [8:0] obs [84];
    logic [7:0] mdl [80];
    logic       prev_stall = 1'b0;
    logic [8:0] prev_out = 9'h000;

    logic [7:0] line_cmds [4] = '{8'h80, 8'hC0, 8'h94, 8'hD4};

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic rs, input logic [7:0] data, input int gap, input int idle);
        exp_t e;
        e.rs = rs;
        e.data = data;
        e.gap = gap;
        e.idle = idle;
        exp_q.push_back(e);
    endtask

    task automatic push_init();
        push(1'b0, 8'h28, PwrWait + 1, -1);
        push(1'b0, 8'h0C, 1, -1);
        push(1'b0, 8'h06, 1, -1);
        push(1'b0, 8'h01, 1, -1);
    endtask

    task automatic push_frame(input int first_gap, input int first_idle, input bit strict);
        for (int r = 0; r < 4; r++) begin
            push(1'b0, line_cmds[r], (r == 0) ? first_gap : (strict ? 1 : -1),
                 (r == 0) ? first_idle : -1);
            for (int c = 0; c < 20; c++) begin
                push(1'b1, mdl[r * 20 + c], strict ? 1 : -1, -1);
            end
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 80; i++) mdl[i] = 8'h20;
    endtask

    task automatic write_char(input logic [1:0] row, input logic [4:0] col,
                              input logic [7:0] ch);
        wr_en = 1'b1;
        wr_row = row;
        wr_col = col;
        wr_char = ch;
        tick();
        wr_en = 1'b0;
        if (col < 5'd20) mdl[int'(row) * 20 + int'(col)] = ch;
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic wait_xfer(input string name, input int target, input int budget);
        int n = 0;
        while (xfer_n < target && n < budget) begin
            tick();
            n++;
        end
        check(name, 64'(xfer_n >= target), 64'd1);
    endtask

    // Monitor: compares every accepted transfer and the hold behaviour under back-pressure.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            last_cyc = cyc;
            idle_cnt = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold", {out_valid, out_rs, out_data}, {1'b1, prev_out});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_xfer: got rs=%0b data=%0h, expected no transfer",
                             out_rs, out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("xfer_byte", {out_rs, out_data}, {mon_e.rs, mon_e.data});
                    if (mon_e.gap >= 0) check("xfer_gap", 64'(cyc - last_cyc), 64'(mon_e.gap));
                    if (mon_e.idle >= 0) check("busy_low_cycles", 64'(idle_cnt),
                                               64'(mon_e.idle));
                end
                if (xfer_n < 84) obs[xfer_n] = {out_rs, out_data};
                xfer_n++;
                last_cyc = cyc;
                idle_cnt = 0;
            end else if (!busy) begin
                idle_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_out = {out_rs, out_data};
        end
    end

    initial begin
        int found;

        // Reset state.
        clear_model();
        repeat (3) tick();
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b1);
        check("rst_init_done", init_done, 1'b0);
        check("rst_out_rs", out_rs, 1'b0);
        check("rst_out_data", out_data, 8'h00);

        // 1: power-up wait, init commands, clear wait, first frame of spaces.
        push_init();
        push_frame(ClrWait + 1, -1, 1'b1);
        tick();
        rst = 1'b1;
        wait_empty("t1_frame_done", 600);
        tick();
        check("t1_busy_idle", busy, 1'b0);
        check("t1_init_done", init_done, 1'b1);
        check("t1_no_valid", out_valid, 1'b0);

        // 2: random writes, out-of-range column ignored.
        write_char(2'd1, 5'd0, 8'h47);
        write_char(2'd3, 5'd19, 8'h64);
        write_char(2'd2, 5'd25, 8'h58);
        xfer_n = 0;
        push_frame(-1, -1, 1'b1);
        pulse_refresh();
        wait_empty("t2_frame_done", 300);
        check("t2_xfer22", obs[22], {1'b1, 8'h47});
        check("t2_xfer83", obs[83], {1'b1, 8'h64});
        found = 0;
        for (int i = 0; i < 84; i++) if (obs[i][7:0] == 8'h58) found++;
        check("t2_no_58", 64'(found), 64'd0);

        // 3: 7-cycle back-pressure during the character stream.
        xfer_n = 0;
        push_frame(-1, -1, 1'b0);
        pulse_refresh();
        wait_xfer("t3_reach_10", 10, 100);
        out_ready = 1'b0;
        repeat (7) tick();
        out_ready = 1'b1;
        wait_empty("t3_frame_done", 300);
        tick();
        check("t3_xfer_count", 64'(xfer_n), 64'd84);

        // 4: three refresh pulses during a scan-out coalesce into one extra frame.
        xfer_n = 0;
        push_frame(-1, -1, 1'b1);
        push_frame(2, 1, 1'b1);
        pulse_refresh();
        wait_xfer("t4_reach_5", 5, 100);
        pulse_refresh();
        repeat (3) tick();
        pulse_refresh();
        wait_xfer("t4_reach_30", 30, 100);
        pulse_refresh();
        wait_empty("t4_frames_done", 600);
        repeat (4) tick();
        check("t4_xfer_count", 64'(xfer_n), 64'd168);
        check("t4_busy_idle", busy, 1'b0);

        // 5: write lands mid-frame ahead of the scan pointer.
        xfer_n = 0;
        mdl[60] = 8'h5A;
        push_frame(-1, -1, 1'b1);
        pulse_refresh();
        wait_xfer("t5_reach_40", 40, 100);
        write_char(2'd3, 5'd0, 8'h5A);
        wait_empty("t5_frame_done", 300);
        check("t5_xfer64", obs[64], {1'b1, 8'h5A});

        // 6: one-cycle reset mid-frame restarts everything.
        xfer_n = 0;
        push_frame(-1, -1, 1'b1);
        pulse_refresh();
        wait_xfer("t6_reach_30", 30, 100);
        rst = 1'b0;
        exp_q.delete();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("t6_out_valid", out_valid, 1'b0);
        check("t6_busy", busy, 1'b1);
        check("t6_init_done", init_done, 1'b0);
        clear_model();
        push_init();
        push_frame(ClrWait + 1, -1, 1'b1);
        wait_empty("t6_reinit_done", 600);
        tick();
        check("t6_init_done_again", init_done, 1'b1);
        check("t6_busy_idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        n_fail++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
